// File: rtl/contador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : contador_pkg
//  Description : Shared definitions for the BCD counter chain run control:
//                FSM state encoding and default terminal digit values.
//  Revision    : 1.0 - initial release
// ============================================================================
package contador_pkg;

  // The state encoding is also driven onto the LED port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Default terminal count 9675, most significant digit first.
  localparam logic [3:0] MAX3_DEFAULT = 4'd9;
  localparam logic [3:0] MAX2_DEFAULT = 4'd6;
  localparam logic [3:0] MAX1_DEFAULT = 4'd7;
  localparam logic [3:0] MAX0_DEFAULT = 4'd5;

  // Largest value a single BCD digit can hold.
  localparam int MAX_CYCLE = 9;

endpackage
`default_nettype wire

// File: rtl/antirrebote.sv
`default_nettype none
// ============================================================================
//  Module      : antirrebote
//  Description : Push-button conditioner: two-flop synchronizer, debouncer
//                that accepts a new level after DEBOUNCE stable cycles, and a
//                one-cycle registered pulse on each accepted rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module antirrebote import contador_pkg::*; #(
  parameter int DEBOUNCE = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronize, count consecutive cycles at the new level, accept and pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This is the DEBOUNCE-th consecutive cycle at the new level.
        level <= sync2;
        cnt   <= '0;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/secuenciador_conteo.sv
`default_nettype none
// ============================================================================
//  Module      : secuenciador_conteo
//  Description : Run-control sequencer for the 4-digit BCD counter chain.
//                Conditions start/stop and clear buttons, prescales the clock
//                into a count tick and drives digit-0 enable and the shared
//                active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_conteo import contador_pkg::*; #(
  parameter int         PRESCALE   = 50_000_000,
  parameter int         PW         = 26,
  parameter int         DEBOUNCE   = 500_000,
  parameter logic [3:0] MAX_COUNT3 = MAX3_DEFAULT,
  parameter logic [3:0] MAX_COUNT2 = MAX2_DEFAULT,
  parameter logic [3:0] MAX_COUNT1 = MAX1_DEFAULT,
  parameter logic [3:0] MAX_COUNT0 = MAX0_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic [3:0] Qdata3,
  input  logic [3:0] Qdata2,
  input  logic [3:0] Qdata1,
  input  logic [3:0] Qdata0,
  input  logic       mode,
  output logic       ena0,
  output logic       clr_n,
  output logic [1:0] state,
  output logic       done
);

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  state_t        st;
  logic [PW-1:0] pre;
  logic          ss_p;
  logic          clr_p;
  logic          tick;
  logic          term;

  antirrebote #(.DEBOUNCE(DEBOUNCE)) u_ss (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start_stop),
    .pulse (ss_p)
  );

  antirrebote #(.DEBOUNCE(DEBOUNCE)) u_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .pulse (clr_p)
  );

  // Digit values only matter on a tick, so glitches elsewhere are harmless.
  assign term  = (Qdata3 == MAX_COUNT3) && (Qdata2 == MAX_COUNT2) &&
                 (Qdata1 == MAX_COUNT1) && (Qdata0 == MAX_COUNT0);
  assign tick  = (st == ST_RUN) && (pre == PRE_LAST);
  assign state = st;

  // Sequencer FSM with prescaler and registered outputs; clear beats start/stop beats tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_IDLE;
      pre   <= '0;
      ena0  <= 1'b0;
      clr_n <= 1'b0;
      done  <= 1'b0;
    end else begin
      ena0  <= 1'b0;
      clr_n <= 1'b1;
      if (clr_p) begin
        st    <= ST_IDLE;
        pre   <= '0;
        clr_n <= 1'b0;
        done  <= 1'b0;
      end else begin
        unique case (st)
          ST_IDLE: begin
            pre <= '0;
            if (ss_p) st <= ST_RUN;
          end
          ST_RUN: begin
            // The prescaler keeps its cadence on the edge that leaves RUN.
            pre <= tick ? '0 : pre + 1'b1;
            if (ss_p) begin
              st <= ST_PAUSE;
            end else if (tick) begin
              if (term && mode) begin
                st   <= ST_DONE;
                done <= 1'b1;
              end else begin
                ena0 <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (ss_p) st <= ST_RUN;
          end
          ST_DONE: begin
            pre <= '0;
            if (ss_p) begin
              st    <= ST_IDLE;
              clr_n <= 1'b0;
              done  <= 1'b0;
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/secuenciador_conteo.md
# secuenciador_conteo

Run-control sequencer for the 4-digit BCD counter chain (digits 3..0, terminal value 9675). It turns two raw push-buttons into start/stop and clear commands, divides the system clock into a count tick, and drives the count enable of digit 0 and the active-low clear of all four digit counters. The digit counters and the combinational carry/reset controller stay unchanged downstream; this block only decides when they advance and when they clear.

## Interface
- `PRESCALE`, default 50_000_000: clock cycles per count tick; minimum 2.
- `PW`, default 26: prescaler width; must satisfy 2^PW ≥ PRESCALE.
- `DEBOUNCE`, default 500_000: consecutive stable cycles required to accept a button level; minimum 1.
- `MAX_COUNT3`/`2`/`1`/`0`, defaults 9/6/7/5: terminal digit values.
- `clk` in 1: system clock; one clock domain, all logic rising-edge.
- `rst` in 1: reset; synchronous and active-high.
- `btn_start_stop` in 1: raw asynchronous button, active-high.
- `btn_clear` in 1: raw asynchronous button, active-high.
- `Qdata3`..`Qdata0` in 4 each: current BCD digits from the counters.
- `mode` in 1: 0 = wrap at terminal; 1 = stop at terminal. Quasi-static.
- `ena0` out 1: one-cycle count enable to digit 0.
- `clr_n` out 1: active-low clear to all digit counters.
- `state` out 2: FSM state, for LEDs.
- `done` out 1: high while in DONE.

## Operation
- Button path, per button: 2-flop synchronizer, then debouncer. The accepted level changes only after the synchronized input has held the new value for `DEBOUNCE` consecutive cycles. A rising edge of the accepted level produces a one-cycle pulse: `ss_p` or `clr_p`.
- Prescaler: `PW`-bit counter counting 0..PRESCALE-1 and wrapping, in RUN only.
  - Holds its value in PAUSE.
  - Forced to 0 in IDLE and DONE.
  - `tick` = RUN and count == PRESCALE-1.
- Terminal: `term` = all four `Qdata` equal their `MAX_COUNT` values.
- FSM states (2-bit encoding on `state`): IDLE=00, RUN=01, PAUSE=10, DONE=11.
  - IDLE: `ss_p` → RUN.
  - RUN: `ss_p` → PAUSE. On `tick`:
    - `term` and `mode`=1 → DONE, no `ena0` issued.
    - Otherwise `ena0` pulses. With `term` and `mode`=0, the downstream controller wraps the counters to 0000.
  - PAUSE: `ss_p` → RUN, resuming the prescaler from its held value.
  - DONE: `ss_p` → IDLE.
- Clear:
  - `clr_p` in any state → IDLE, and `clr_n` = 0 for exactly one cycle.
  - Leaving DONE via `ss_p` also drives `clr_n` low for one cycle.
- Priority within one cycle: `rst` > `clr_p` > `ss_p` > `tick`. If `tick` and `ss_p` coincide in RUN, the state goes to PAUSE and no `ena0` is issued.
- `Qdata` values are sampled only on `tick`; their glitches at other times are ignored.

## Timing
- All outputs are registered.
- Reset values: `state`=IDLE, `ena0`=0, `clr_n`=0, `done`=0, prescaler 0, synchronizers and debouncers 0. `clr_n` returns to 1 on the first cycle after `rst` deasserts.
- Button latency: a raw edge gives a pulse after 2 + `DEBOUNCE` cycles. The state change and `clr_n` appear on the following edge.
- `ena0` is high in the cycle after the edge where `tick` was true. Tick period is exactly `PRESCALE` cycles while continuously in RUN.
- The first `ena0` after IDLE→RUN arrives `PRESCALE` cycles after entering RUN.
- `rst` asserted mid-count: all registers reach reset values at that edge. No partial `ena0` pulse follows.

## Structure
- Shared package `contador_pkg`:
  - state encoding constants `ST_IDLE`, `ST_RUN`, `ST_PAUSE`, `ST_DONE`;
  - default terminal digits 9/6/7/5;
  - `MAX_CYCLE`=9.
- One sub-module, `antirrebote`: synchronizer, debouncer and rising-edge pulse, parameterized by `DEBOUNCE`. Instantiated twice.
- FSM, prescaler and terminal compare live in the top module.

## Test plan
Run with `PRESCALE`=4 and `DEBOUNCE`=3.
- Reset then idle: hold `rst` 2 cycles, buttons low → `state`=00, `clr_n`=0 during reset and 1 after; `ena0` never pulses.
- Start and count: press `btn_start_stop` 6 cycles → RUN 6 cycles after the press; `ena0` pulses every 4 cycles thereafter.
- Bounce rejection: toggle `btn_clear` every 2 cycles for 20 cycles → no `clr_p`; `clr_n` stays 1.
- Pause/resume: pause with prescaler at 2, hold 10 cycles, resume → first `ena0` 2 cycles after RUN re-entry.
- Terminal, `mode`=1: `Qdata`=9,6,7,5 in RUN → at the next tick `state`=11, `done`=1, no `ena0`; press start/stop → IDLE with a one-cycle `clr_n`=0.
- Terminal, `mode`=0, plus priority: same digits → `ena0` pulses and the state stays RUN. `clr_p` coinciding with `tick` → IDLE, `clr_n`=0, no `ena0`.
